// File: rtl/inst_fetch_buffer_pkg.sv
// Shared fetch-path types for the fetch buffer and its neighbours.
package inst_fetch_buffer_pkg;

  typedef logic [31:0] InstAddr_t;
  typedef logic [31:0] Inst_t;
  typedef logic        Bit_t;

  typedef struct packed {
    InstAddr_t pc;
    Inst_t     inst;
    Bit_t      except;
  } FetchEntry_t;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side push, ID-side pop and the two-slot head view of the fetch buffer.
interface inst_fetch_buffer_if #(parameter int DEPTH = 8);
  import inst_fetch_buffer_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic [1:0]      push_cnt;
  InstAddr_t       push_pc;
  Inst_t           push_inst1;
  Inst_t           push_inst2;
  Bit_t            push_except;
  logic            push_ready;
  logic [1:0]      pop_cnt;
  logic            out_valid1;
  logic            out_valid2;
  InstAddr_t       out_pc1;
  InstAddr_t       out_pc2;
  Inst_t           out_inst1;
  Inst_t           out_inst2;
  Bit_t            out_except1;
  Bit_t            out_except2;
  logic [CW-1:0]   occupancy;

  // Driven by the fetch unit / ID stage side.
  modport master (
    output flush, push_cnt, push_pc, push_inst1, push_inst2, push_except, pop_cnt,
    input  push_ready, out_valid1, out_valid2, out_pc1, out_pc2,
           out_inst1, out_inst2, out_except1, out_except2, occupancy
  );

  // The buffer itself.
  modport slave (
    input  flush, push_cnt, push_pc, push_inst1, push_inst2, push_except, pop_cnt,
    output push_ready, out_valid1, out_valid2, out_pc1, out_pc2,
           out_inst1, out_inst2, out_except1, out_except2, occupancy
  );

endinterface

// File: rtl/inst_fetch_buffer.sv
// Dual-push / dual-pop circular instruction queue between fetch and ID.
// The two oldest entries are presented combinationally; a pushed word is
// visible one cycle after the push (no bypass).
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  inst_fetch_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  FetchEntry_t   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic [1:0]    push_acc;
  logic [1:0]    pop_eff;

  assign head_p1 = head + PW'(1);
  assign tail_p1 = tail + PW'(1);

  // Readiness comes from the registered count only, so no path from ID pop.
  assign bus.push_ready = (cnt <= READY_MAX);
  assign bus.occupancy  = cnt;

  // Accepted push count (illegal 3 is dropped) and pop clamped to live entries.
  always_comb begin
    push_acc = 2'd0;
    pop_eff  = 2'd0;
    if (bus.push_ready && !bus.flush && (bus.push_cnt != 2'd3)) begin
      push_acc = bus.push_cnt;
    end
    if ((bus.pop_cnt >= 2'd2) && (cnt >= CW'(2))) begin
      pop_eff = 2'd2;
    end else if ((bus.pop_cnt != 2'd0) && (cnt != '0)) begin
      pop_eff = 2'd1;
    end
  end

  // Storage writes; contents are deliberately left alone by reset and flush.
  always_ff @(posedge clk) begin
    if (push_acc >= 2'd1) begin
      mem[tail] <= '{pc: bus.push_pc, inst: bus.push_inst1, except: bus.push_except};
    end
    if (push_acc == 2'd2) begin
      mem[tail_p1] <= '{pc: bus.push_pc + 32'd4, inst: bus.push_inst2, except: bus.push_except};
    end
  end

  // Pointer and count update; flush overrides any push or pop this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop_eff);
      tail <= tail + PW'(push_acc);
      cnt  <= cnt + CW'(push_acc) - CW'(pop_eff);
    end
  end

  // Two-wide head view; empty slots drive zeros.
  always_comb begin
    bus.out_valid1  = (cnt != '0);
    bus.out_valid2  = (cnt >= CW'(2));
    bus.out_pc1     = ZERO_WORD;
    bus.out_inst1   = ZERO_WORD;
    bus.out_except1 = 1'b0;
    bus.out_pc2     = ZERO_WORD;
    bus.out_inst2   = ZERO_WORD;
    bus.out_except2 = 1'b0;
    if (bus.out_valid1) begin
      bus.out_pc1     = mem[head].pc;
      bus.out_inst1   = mem[head].inst;
      bus.out_except1 = mem[head].except;
    end
    if (bus.out_valid2) begin
      bus.out_pc2     = mem[head_p1].pc;
      bus.out_inst2   = mem[head_p1].inst;
      bus.out_except2 = mem[head_p1].except;
    end
  end

endmodule
